branch_predictor: RTL

- Parametrised direct-mapped branch target buffer (BTB) with saturating-counter direction prediction.
- Sits beside the PC in the pipelined datapath:
  - The fetch stage looks up the current PC and gets a predicted next PC.
  - The memory stage, where branch outcome and target are resolved, writes the resolved outcome back.
- Replaces the fixed "PC+4 until resolved" policy. Flushes happen only on a reported mispredict.

---
 rtl/branch_predictor_if.sv | 36 +++
 rtl/branch_predictor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/memory-stage bus between the pipeline and the branch predictor.
// The pipeline drives the fetch PC and the resolved-branch update. The
// predictor returns the prediction, the flush request and the statistics.
interface branch_predictor_if;
    // fetch-stage lookup
    logic [31:0] pc_IF;
    logic        pred_taken;
    logic [31:0] pred_target;
    // pipeline advance qualifier
    logic        enable;
    // memory-stage resolution
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    // statistics
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    // pipeline side
    modport master (
        output pc_IF, enable, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, stat_branches, stat_mispredicts
    );

    // predictor side
    modport slave (
        input  pc_IF, enable, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational from stored state (no bypass of a same-cycle
// update); updates are applied on the rising edge when upd_valid && enable.
// Optional feature macro: BPRED_GSHARE_EN -- moves the direction counters
// into their own table indexed by (pc index XOR global history).
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic               CLK,
    input  logic               nRST,
    branch_predictor_if.slave  bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    // weakly taken = MSB set, rest clear; weakly not-taken is one below
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(CNT_WT - CNT_W'(1));

    // saturating counter step towards taken (up=1) or not-taken (up=0)
    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                  input logic             up);
        logic [CNT_W-1:0] n;
        if (up) begin
            n = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
        end else begin
            n = (c == {CNT_W{1'b0}}) ? c : c - CNT_W'(1);
        end
        return n;
    endfunction

    // table storage
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [CNT_W-1:0] r_cnt    [ENTRIES];
    logic [31:0]      r_stat_br;
    logic [31:0]      r_stat_mp;
`ifdef BPRED_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;
`endif

    // lookup side
    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_lk_cidx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_lk_taken;

    // update side
    logic [IDX_W-1:0] w_up_idx;
    logic [IDX_W-1:0] w_up_cidx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_apply;
    logic             w_mispredict;
    logic             w_unused;

    assign w_lk_idx = bp.pc_IF[IDX_W+1:2];
    assign w_lk_tag = bp.pc_IF[31:IDX_W+2];
    assign w_up_idx = bp.upd_pc[IDX_W+1:2];
    assign w_up_tag = bp.upd_pc[31:IDX_W+2];

    // byte-offset bits carry no information for word-aligned instructions
    assign w_unused = ^{bp.pc_IF[1:0], bp.upd_pc[1:0]};

`ifdef BPRED_GSHARE_EN
    // counters hashed with global history; update uses pre-shift history
    assign w_lk_cidx = w_lk_idx ^ r_ghr;
    assign w_up_cidx = w_up_idx ^ r_ghr;
`else
    // counters live inside the BTB entry
    assign w_lk_cidx = w_lk_idx;
    assign w_up_cidx = w_up_idx;
`endif

    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_cnt[w_lk_cidx][CNT_W-1];

    assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_apply    = bp.upd_valid && bp.enable;

    // flush request does not depend on enable: it describes the instruction
    assign w_mispredict = bp.upd_valid &&
                          ((bp.upd_taken != bp.upd_pred_taken) ||
                           (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

    assign bp.pred_taken       = w_lk_taken;
    assign bp.pred_target      = w_lk_taken ? r_target[w_lk_idx] : bp.pc_IF + 32'd4;
    assign bp.mispredict       = w_mispredict;
    assign bp.stat_branches    = r_stat_br;
    assign bp.stat_mispredicts = r_stat_mp;

    // BTB entries and direction counters: train on hit, allocate on taken miss
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_WNT;
            end
        end else if (w_apply) begin
            if (w_up_hit) begin
                r_cnt[w_up_cidx] <= sat_step(r_cnt[w_up_cidx], bp.upd_taken);
                if (bp.upd_taken) begin
                    r_target[w_up_idx] <= bp.upd_target;
                end
            end else if (bp.upd_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= bp.upd_target;
                r_cnt[w_up_cidx]   <= CNT_WT;
            end
        end
    end

    // statistics counters, free-running with natural 32-bit wrap
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (w_apply) begin
            r_stat_br <= r_stat_br + 32'd1;
            if (w_mispredict) begin
                r_stat_mp <= r_stat_mp + 32'd1;
            end
        end
    end

`ifdef BPRED_GSHARE_EN
    // global history: shift in every applied outcome, newest at bit 0
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ghr <= '0;
        end else if (w_apply) begin
            r_ghr <= (r_ghr << 1) | IDX_W'(bp.upd_taken);
        end
    end
`endif

endmodule
